// File: rtl/xosera_pkg.sv
// ----------------------------------------------------------------------------
// xosera_pkg
//   Shared types for the VRAM path: address/word types, the arbitration owner
//   encoding reported on owner_o, and the blit lock FSM state.
//   No ports (package).
// ----------------------------------------------------------------------------
package xosera_pkg;

   typedef logic [15:0] addr_t;
   typedef logic [15:0] word_t;

   // Who owns the VRAM port in a given cycle. ARB_NONE means the port is idle.
   typedef enum logic [1:0] {
      ARB_NONE = 2'd0,
      ARB_VGEN = 2'd1,
      ARB_REGS = 2'd2,
      ARB_BLIT = 2'd3
   } arb_owner_t;

   // Blit lock FSM: S_LOCK keeps regs off the port so a blit read-modify-write
   // pair cannot be split.
   typedef enum logic {
      S_IDLE = 1'b0,
      S_LOCK = 1'b1
   } sched_state_t;

endpackage

// File: rtl/vram.sv
// ----------------------------------------------------------------------------
// vram
//   Single-port 64K x 16 video RAM with nibble write enables. One access per
//   cycle; read data appears on data_out the cycle after sel. A write cycle
//   also returns the pre-write contents of the addressed word.
// Ports
//   clk         in   system clock
//   sel         in   access this cycle
//   wr_en       in   write (1) or read (0)
//   wr_mask     in   4   per-nibble write enable, bit i -> data[4i+3:4i]
//   address_in  in   16  word address
//   data_in     in   16  write data
//   data_out    out  16  registered read data
// ----------------------------------------------------------------------------
module vram
   import xosera_pkg::*;
(
   input  logic       clk,
   input  logic       sel,
   input  logic       wr_en,
   input  logic [3:0] wr_mask,
   input  addr_t      address_in,
   input  word_t      data_in,
   output word_t      data_out
);

   word_t mem_r [0:65535];

   // Memory array access: masked nibble writes plus registered read port.
   always_ff @(posedge clk) begin
      if (sel) begin
         if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
               if (wr_mask[i]) begin
                  mem_r[address_in][i*4 +: 4] <= data_in[i*4 +: 4];
               end
            end
         end
         data_out <= mem_r[address_in];
      end
   end

endmodule

// File: rtl/vram_sched.sv
// ----------------------------------------------------------------------------
// vram_sched
//   VRAM access scheduler for video generation (vgen), the register interface
//   (regs) and the 2D blitter (blit), driving one single-port vram.
//   vgen has absolute priority so display timing stays deterministic. regs and
//   blit share the remaining cycles round-robin; a requester that has been
//   denied STARVE_MAX eligible cycles becomes urgent and wins over a
//   non-urgent peer. blit may lock the port for up to LOCK_MAX cycles to keep a
//   read-modify-write pair together; running into that bound forces a release
//   and hands the next turn to regs.
// Parameters
//   EN_BLIT     0 disables the blitter path entirely
//   STARVE_MAX  denied-eligible cycles before a requester turns urgent (>=1)
//   LOCK_MAX    maximum consecutive S_LOCK cycles (>=1)
// Ports
//   clk, reset_n                     clock, async active-low reset
//   vgen_sel_i / vgen_addr_i         one-cycle vgen read, no ack
//   regs_sel_i ... regs_data_i       regs request (held until regs_ack_o)
//   regs_ack_o                       one-cycle ack, read data on vram_data_o
//   blit_sel_i ... blit_data_i       blit request (held until blit_ack_o)
//   blit_lock_i                      keep ownership after current grant
//   blit_ack_o                       one-cycle ack, read data on vram_data_o
//   vram_data_o                      VRAM read data
//   owner_o                          owner of the access whose data is shown
//   regs_starve_o                    regs starve counter saturated
//   lock_timeout_o                   one-cycle pulse on forced lock release
// ----------------------------------------------------------------------------
module vram_sched
   import xosera_pkg::*;
#(
   parameter int EN_BLIT    = 1,
   parameter int STARVE_MAX = 8,
   parameter int LOCK_MAX   = 4
)(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       vgen_sel_i,
   input  addr_t      vgen_addr_i,
   input  logic       regs_sel_i,
   output logic       regs_ack_o,
   input  logic       regs_wr_i,
   input  logic [3:0] regs_wr_mask_i,
   input  addr_t      regs_addr_i,
   input  word_t      regs_data_i,
   input  logic       blit_sel_i,
   input  logic       blit_lock_i,
   output logic       blit_ack_o,
   input  logic       blit_wr_i,
   input  logic [3:0] blit_wr_mask_i,
   input  addr_t      blit_addr_i,
   input  word_t      blit_data_i,
   output word_t      vram_data_o,
   output arb_owner_t owner_o,
   output logic       regs_starve_o,
   output logic       lock_timeout_o
);

   localparam int             SCW        = $clog2(STARVE_MAX + 1);
   localparam int             LCW        = $clog2(LOCK_MAX + 1);
   localparam logic [SCW-1:0] STARVE_TOP = SCW'(STARVE_MAX);
   localparam logic [LCW-1:0] LOCK_LAST  = LCW'(LOCK_MAX - 1);
   localparam logic           EN_BLIT_L  = (EN_BLIT != 0);

   sched_state_t   state_r;
   logic [LCW-1:0] lock_cnt_r;
   arb_owner_t     rr_ptr_r;
   logic [SCW-1:0] regs_cnt_r;
   logic [SCW-1:0] blit_cnt_r;
   logic           relock_inh_r;

   logic           regs_elig_s;
   logic           blit_req_s;
   logic           blit_elig_s;
   logic           regs_urg_s;
   logic           blit_urg_s;
   arb_owner_t     grant_s;
   logic [SCW-1:0] regs_cnt_nxt_s;
   logic [SCW-1:0] blit_cnt_nxt_s;
   logic           lock_timeout_s;
   logic           lock_release_s;
   logic           lock_enter_s;
   logic           inh_eff_s;

   logic           vram_sel_s;
   logic           vram_wr_s;
   logic [3:0]     vram_mask_s;
   addr_t          vram_addr_s;
   word_t          vram_wdata_s;

   // Saturating starve counter shared by regs and blit. Dropping sel or being
   // granted clears it; being eligible but passed over counts up; a
   // requester that is held off (ack cycle, lock) keeps its count.
   function automatic logic [SCW-1:0] starve_next(
      input logic [SCW-1:0] cnt,
      input logic           sel,
      input logic           elig,
      input logic           granted
   );
      logic [SCW-1:0] nxt;
      if (!sel || granted) begin
         nxt = SCW'(0);
      end else if (elig && (cnt != STARVE_TOP)) begin
         nxt = cnt + SCW'(1);
      end else begin
         nxt = cnt;
      end
      return nxt;
   endfunction

   // The ack cycle blocks a back-to-back grant, so one requester gets at most
   // every second cycle.
   assign regs_elig_s = regs_sel_i & ~regs_ack_o & (state_r != S_LOCK);
   assign blit_req_s  = EN_BLIT_L & blit_sel_i;
   assign blit_elig_s = blit_req_s & ~blit_ack_o;
   assign regs_urg_s  = regs_elig_s & (regs_cnt_r == STARVE_TOP);
   assign blit_urg_s  = blit_elig_s & (blit_cnt_r == STARVE_TOP);

   // Grant selection: vgen, then locked blit, then a lone urgent requester,
   // otherwise round-robin between whoever is eligible.
   always_comb begin
      grant_s = ARB_NONE;
      if (vgen_sel_i) begin
         grant_s = ARB_VGEN;
      end else if (state_r == S_LOCK) begin
         if (blit_elig_s) begin
            grant_s = ARB_BLIT;
         end else begin
            grant_s = ARB_NONE;
         end
      end else if (regs_urg_s && !blit_urg_s) begin
         grant_s = ARB_REGS;
      end else if (blit_urg_s && !regs_urg_s) begin
         grant_s = ARB_BLIT;
      end else if (rr_ptr_r == ARB_REGS) begin
         if (regs_elig_s) begin
            grant_s = ARB_REGS;
         end else if (blit_elig_s) begin
            grant_s = ARB_BLIT;
         end else begin
            grant_s = ARB_NONE;
         end
      end else begin
         if (blit_elig_s) begin
            grant_s = ARB_BLIT;
         end else if (regs_elig_s) begin
            grant_s = ARB_REGS;
         end else begin
            grant_s = ARB_NONE;
         end
      end
   end

   assign regs_cnt_nxt_s = starve_next(regs_cnt_r, regs_sel_i, regs_elig_s,
                                       grant_s == ARB_REGS);
   assign blit_cnt_nxt_s = starve_next(blit_cnt_r, blit_req_s, blit_elig_s,
                                       grant_s == ARB_BLIT);

   // Re-lock stays blocked after a timeout until regs has been served or has
   // stopped asking; a low regs_sel_i lifts the block in the same cycle.
   assign inh_eff_s      = relock_inh_r & regs_sel_i;
   assign lock_timeout_s = (state_r == S_LOCK) && (lock_cnt_r == LOCK_LAST);
   assign lock_release_s = (state_r == S_LOCK) && (!blit_lock_i || !blit_sel_i);
   assign lock_enter_s   = EN_BLIT_L && (state_r == S_IDLE) && (grant_s == ARB_BLIT)
                           && blit_lock_i && !inh_eff_s;

   // VRAM port mux; vgen is read-only and an idle port does nothing.
   always_comb begin
      vram_sel_s   = 1'b0;
      vram_wr_s    = 1'b0;
      vram_mask_s  = 4'h0;
      vram_addr_s  = 16'h0000;
      vram_wdata_s = 16'h0000;
      case (grant_s)
         ARB_VGEN: begin
            vram_sel_s  = 1'b1;
            vram_addr_s = vgen_addr_i;
         end
         ARB_REGS: begin
            vram_sel_s   = 1'b1;
            vram_wr_s    = regs_wr_i;
            vram_mask_s  = regs_wr_mask_i;
            vram_addr_s  = regs_addr_i;
            vram_wdata_s = regs_data_i;
         end
         ARB_BLIT: begin
            vram_sel_s   = 1'b1;
            vram_wr_s    = blit_wr_i;
            vram_mask_s  = blit_wr_mask_i;
            vram_addr_s  = blit_addr_i;
            vram_wdata_s = blit_data_i;
         end
         default: begin
            vram_sel_s = 1'b0;
         end
      endcase
   end

   // Scheduler state: acks/owner, round-robin pointer, starve counters and
   // the blit lock FSM with its timeout.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         regs_ack_o     <= 1'b0;
         blit_ack_o     <= 1'b0;
         owner_o        <= ARB_NONE;
         regs_starve_o  <= 1'b0;
         lock_timeout_o <= 1'b0;
         rr_ptr_r       <= ARB_REGS;
         regs_cnt_r     <= SCW'(0);
         blit_cnt_r     <= SCW'(0);
         lock_cnt_r     <= LCW'(0);
         relock_inh_r   <= 1'b0;
         state_r        <= S_IDLE;
      end else begin
         regs_ack_o     <= (grant_s == ARB_REGS);
         blit_ack_o     <= (grant_s == ARB_BLIT);
         owner_o        <= grant_s;
         regs_cnt_r     <= regs_cnt_nxt_s;
         blit_cnt_r     <= blit_cnt_nxt_s;
         regs_starve_o  <= (regs_cnt_nxt_s == STARVE_TOP);
         lock_timeout_o <= 1'b0;

         case (grant_s)
            ARB_REGS: rr_ptr_r <= ARB_BLIT;
            ARB_BLIT: rr_ptr_r <= ARB_REGS;
            default:  rr_ptr_r <= rr_ptr_r;
         endcase

         if ((grant_s == ARB_REGS) || !regs_sel_i) begin
            relock_inh_r <= 1'b0;
         end else begin
            relock_inh_r <= relock_inh_r;
         end

         // Later assignments below (timeout) override the defaults above.
         case (state_r)
            S_IDLE: begin
               lock_cnt_r <= LCW'(0);
               if (lock_enter_s) begin
                  state_r <= S_LOCK;
               end else begin
                  state_r <= S_IDLE;
               end
            end
            S_LOCK: begin
               if (lock_timeout_s) begin
                  state_r        <= S_IDLE;
                  lock_cnt_r     <= LCW'(0);
                  lock_timeout_o <= 1'b1;
                  rr_ptr_r       <= ARB_REGS;
                  relock_inh_r   <= 1'b1;
               end else if (lock_release_s) begin
                  state_r    <= S_IDLE;
                  lock_cnt_r <= LCW'(0);
               end else begin
                  state_r    <= S_LOCK;
                  lock_cnt_r <= lock_cnt_r + LCW'(1);
               end
            end
            default: begin
               state_r    <= S_IDLE;
               lock_cnt_r <= LCW'(0);
            end
         endcase
      end
   end

   vram u_vram (
      .clk        (clk),
      .sel        (vram_sel_s),
      .wr_en      (vram_wr_s),
      .wr_mask    (vram_mask_s),
      .address_in (vram_addr_s),
      .data_in    (vram_wdata_s),
      .data_out   (vram_data_o)
   );

endmodule

// File: tb/tb_vram_sched.sv
// ----------------------------------------------------------------------------
// tb_vram_sched
//   Directed bench for vram_sched. u_dut uses the default parameters
//   (EN_BLIT=1, STARVE_MAX=8, LOCK_MAX=4); u_nob has EN_BLIT=0 with its blit
//   request tied high. Inputs change 1 time unit after a rising edge, outputs
//   are sampled 1 time unit after the following rising edge, so each check
//   sees the ack/owner/data produced by the inputs of the previous cycle.
// ----------------------------------------------------------------------------
module tb_vram_sched;
   import xosera_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n;

   logic       vgen_sel;
   addr_t      vgen_addr;
   logic       regs_sel, regs_wr;
   logic [3:0] regs_mask;
   addr_t      regs_addr;
   word_t      regs_data;
   logic       blit_sel, blit_lock, blit_wr;
   logic [3:0] blit_mask;
   addr_t      blit_addr;
   word_t      blit_data;

   logic       a_rack, a_back, a_starve, a_tmo;
   word_t      a_data;
   arb_owner_t a_owner;

   logic       b_vgen_sel = 1'b0;
   logic       b_regs_sel;
   logic       b_blit_sel = 1'b1;
   logic       b_blit_lock = 1'b1;
   logic       b_rack, b_back, b_starve, b_tmo;
   word_t      b_data;
   arb_owner_t b_owner;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   vram_sched #(.EN_BLIT(1), .STARVE_MAX(8), .LOCK_MAX(4)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .vgen_sel_i(vgen_sel), .vgen_addr_i(vgen_addr),
      .regs_sel_i(regs_sel), .regs_ack_o(a_rack), .regs_wr_i(regs_wr),
      .regs_wr_mask_i(regs_mask), .regs_addr_i(regs_addr), .regs_data_i(regs_data),
      .blit_sel_i(blit_sel), .blit_lock_i(blit_lock), .blit_ack_o(a_back),
      .blit_wr_i(blit_wr), .blit_wr_mask_i(blit_mask), .blit_addr_i(blit_addr),
      .blit_data_i(blit_data),
      .vram_data_o(a_data), .owner_o(a_owner),
      .regs_starve_o(a_starve), .lock_timeout_o(a_tmo)
   );

   vram_sched #(.EN_BLIT(0), .STARVE_MAX(8), .LOCK_MAX(4)) u_nob (
      .clk(clk), .reset_n(reset_n),
      .vgen_sel_i(b_vgen_sel), .vgen_addr_i(vgen_addr),
      .regs_sel_i(b_regs_sel), .regs_ack_o(b_rack), .regs_wr_i(regs_wr),
      .regs_wr_mask_i(regs_mask), .regs_addr_i(regs_addr), .regs_data_i(regs_data),
      .blit_sel_i(b_blit_sel), .blit_lock_i(b_blit_lock), .blit_ack_o(b_back),
      .blit_wr_i(blit_wr), .blit_wr_mask_i(blit_mask), .blit_addr_i(blit_addr),
      .blit_data_i(blit_data),
      .vram_data_o(b_data), .owner_o(b_owner),
      .regs_starve_o(b_starve), .lock_timeout_o(b_tmo)
   );

   // One cycle of stimulus: inputs (ra doubles as vgen address) and the
   // expected ack/owner/data one edge later.
   typedef struct {
      logic       vg;
      logic       rs;
      logic       rw;
      logic [3:0] rm;
      addr_t      ra;
      word_t      rd;
      logic       bs;
      logic       bl;
      logic       bw;
      logic [3:0] bm;
      addr_t      ba;
      word_t      bd;
      logic       e_rack;
      logic       e_back;
      arb_owner_t e_own;
      logic       e_chk;
      word_t      e_data;
   } vec_t;

   vec_t vt [18];

   task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, want);
      end
   endtask

   task automatic chk_a(input string tag, input logic er, input logic eb, input arb_owner_t eo);
      chk({tag, " regs_ack"}, 16'(a_rack), 16'(er));
      chk({tag, " blit_ack"}, 16'(a_back), 16'(eb));
      chk({tag, " owner"}, 16'(a_owner), 16'(eo));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      vgen_sel = 1'b0; vgen_addr = 16'h0000;
      regs_sel = 1'b0; regs_wr = 1'b0; regs_mask = 4'h0; regs_addr = 16'h0000; regs_data = 16'h0000;
      blit_sel = 1'b0; blit_lock = 1'b0; blit_wr = 1'b0; blit_mask = 4'h0; blit_addr = 16'h0000; blit_data = 16'h0000;
   endtask

   initial begin
      reset_n    = 1'b1;
      b_regs_sel = 1'b0;
      idle_inputs();
      #1 reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_a("reset", 1'b0, 1'b0, ARB_NONE);
      chk("reset starve", 16'(a_starve), 16'h0000);
      chk("reset timeout", 16'(a_tmo), 16'h0000);
      chk("nob reset ack", 16'(b_rack | b_back | b_starve | b_tmo), 16'h0000);
      chk("nob reset owner", 16'(b_owner), 16'(ARB_NONE));
      @(negedge clk) reset_n = 1'b1;

      //            vg    rs    rw    rm     ra        rd         bs    bl    bw    bm     ba        bd         rack  back  owner     chk   data
      vt[0]  = '{1'b0, 1'b1, 1'b1, 4'hF, 16'h1234, 16'h5555, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b1, 1'b0, ARB_REGS, 1'b0, 16'h0000};
      vt[1]  = '{1'b0, 1'b1, 1'b1, 4'h3, 16'h1234, 16'hABCD, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0, 1'b0, ARB_NONE, 1'b0, 16'h0000};
      vt[2]  = '{1'b0, 1'b1, 1'b1, 4'h3, 16'h1234, 16'hABCD, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b1, 1'b0, ARB_REGS, 1'b0, 16'h0000};
      vt[3]  = '{1'b0, 1'b1, 1'b0, 4'h0, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0, 1'b0, ARB_NONE, 1'b0, 16'h0000};
      vt[4]  = '{1'b0, 1'b1, 1'b0, 4'h0, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b1, 1'b0, ARB_REGS, 1'b1, 16'h55CD};
      vt[5]  = '{1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 4'hF, 16'h0010, 16'h1111, 1'b0, 1'b1, ARB_BLIT, 1'b0, 16'h0000};
      vt[6]  = '{1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0, 1'b0, ARB_NONE, 1'b0, 16'h0000};
      vt[7]  = '{1'b0, 1'b1, 1'b0, 4'h0, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0010, 16'h0000, 1'b1, 1'b0, ARB_REGS, 1'b1, 16'h55CD};
      vt[8]  = '{1'b0, 1'b1, 1'b0, 4'h0, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0010, 16'h0000, 1'b0, 1'b1, ARB_BLIT, 1'b1, 16'h1111};
      vt[9]  = '{1'b0, 1'b1, 1'b0, 4'h0, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0010, 16'h0000, 1'b1, 1'b0, ARB_REGS, 1'b1, 16'h55CD};
      vt[10] = '{1'b0, 1'b1, 1'b0, 4'h0, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0010, 16'h0000, 1'b0, 1'b1, ARB_BLIT, 1'b1, 16'h1111};
      vt[11] = '{1'b0, 1'b1, 1'b0, 4'h0, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0010, 16'h0000, 1'b1, 1'b0, ARB_REGS, 1'b1, 16'h55CD};
      vt[12] = '{1'b0, 1'b1, 1'b0, 4'h0, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0010, 16'h0000, 1'b0, 1'b1, ARB_BLIT, 1'b1, 16'h1111};
      vt[13] = '{1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0, 1'b0, ARB_NONE, 1'b0, 16'h0000};
      vt[14] = '{1'b1, 1'b0, 1'b0, 4'h0, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0, 1'b0, ARB_VGEN, 1'b1, 16'h55CD};
      vt[15] = '{1'b1, 1'b1, 1'b1, 4'hF, 16'h0010, 16'hDEAD, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0, 1'b0, ARB_VGEN, 1'b1, 16'h1111};
      vt[16] = '{1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0010, 16'h0000, 1'b0, 1'b1, ARB_BLIT, 1'b1, 16'h1111};
      vt[17] = '{1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0, 1'b0, ARB_NONE, 1'b0, 16'h0000};

      for (int i = 0; i < 18; i++) begin
         vgen_sel  = vt[i].vg; vgen_addr = vt[i].ra;
         regs_sel  = vt[i].rs; regs_wr   = vt[i].rw; regs_mask = vt[i].rm;
         regs_addr = vt[i].ra; regs_data = vt[i].rd;
         blit_sel  = vt[i].bs; blit_lock = vt[i].bl; blit_wr   = vt[i].bw;
         blit_mask = vt[i].bm; blit_addr = vt[i].ba; blit_data = vt[i].bd;
         step();
         chk_a($sformatf("vec%0d", i), vt[i].e_rack, vt[i].e_back, vt[i].e_own);
         if (vt[i].e_chk) begin
            chk($sformatf("vec%0d data", i), a_data, vt[i].e_data);
         end
      end

      // Starvation under vgen: rr_ptr parked on BLIT, blit joins late so only
      // regs is urgent when vgen lets go.
      idle_inputs();
      regs_sel = 1'b1; regs_addr = 16'h1234;
      step(); chk_a("t3 pre", 1'b1, 1'b0, ARB_REGS);
      regs_sel = 1'b0;
      step(); chk_a("t3 gap", 1'b0, 1'b0, ARB_NONE);
      for (int k = 0; k < 10; k++) begin
         vgen_sel = 1'b1; vgen_addr = 16'h1234;
         regs_sel = 1'b1; blit_addr = 16'h0010;
         blit_sel = (k >= 5) ? 1'b1 : 1'b0;
         step();
         chk_a($sformatf("t3 vgen%0d", k), 1'b0, 1'b0, ARB_VGEN);
         chk($sformatf("t3 starve%0d", k), 16'(a_starve), (k >= 7) ? 16'h0001 : 16'h0000);
      end
      vgen_sel = 1'b0;
      step(); chk_a("t3 urgent", 1'b1, 1'b0, ARB_REGS);
      chk("t3 starve clr", 16'(a_starve), 16'h0000);
      chk("t3 data", a_data, 16'h55CD);
      regs_sel = 1'b0;
      step(); chk_a("t3 blit", 1'b0, 1'b1, ARB_BLIT);
      blit_sel = 1'b0;
      step(); chk_a("t3 idle", 1'b0, 1'b0, ARB_NONE);

      // Lock timeout: 4 S_LOCK cycles with regs held off, then regs first.
      blit_sel = 1'b1; blit_lock = 1'b1; blit_addr = 16'h0010;
      step(); chk_a("t4 c0", 1'b0, 1'b1, ARB_BLIT);
      regs_sel = 1'b1; regs_addr = 16'h1234;
      step(); chk_a("t4 c1", 1'b0, 1'b0, ARB_NONE);
      chk("t4 c1 tmo", 16'(a_tmo), 16'h0000);
      step(); chk_a("t4 c2", 1'b0, 1'b1, ARB_BLIT);
      step(); chk_a("t4 c3", 1'b0, 1'b0, ARB_NONE);
      chk("t4 c3 tmo", 16'(a_tmo), 16'h0000);
      step(); chk_a("t4 c4", 1'b0, 1'b1, ARB_BLIT);
      chk("t4 c4 tmo", 16'(a_tmo), 16'h0001);
      step(); chk_a("t4 c5", 1'b1, 1'b0, ARB_REGS);
      chk("t4 c5 tmo", 16'(a_tmo), 16'h0000);
      chk("t4 c5 data", a_data, 16'h55CD);
      regs_sel = 1'b0;
      step(); chk_a("t4 relock", 1'b0, 1'b1, ARB_BLIT);
      blit_sel = 1'b0; blit_lock = 1'b0;
      step(); chk_a("t4 release", 1'b0, 1'b0, ARB_NONE);
      regs_sel = 1'b1; blit_sel = 1'b1;
      step(); chk_a("t4 after", 1'b1, 1'b0, ARB_REGS);

      // Reset while an ack is showing; rr_ptr was BLIT, reset puts it on REGS.
      reset_n = 1'b0;
      #1;
      chk_a("t1 in reset", 1'b0, 1'b0, ARB_NONE);
      chk("t1 reset starve", 16'(a_starve), 16'h0000);
      @(negedge clk) reset_n = 1'b1;
      step(); chk_a("t1 regrant", 1'b1, 1'b0, ARB_REGS);
      idle_inputs();
      step();

      // EN_BLIT=0 instance: blit request always high, never acked.
      regs_mask = 4'hF; regs_addr = 16'h0042; regs_data = 16'h2468;
      for (int k = 0; k < 8; k++) begin
         b_regs_sel = 1'b1;
         regs_wr    = (k == 0) ? 1'b1 : 1'b0;
         step();
         chk($sformatf("t6 regs_ack%0d", k), 16'(b_rack), (k % 2 == 0) ? 16'h0001 : 16'h0000);
         chk($sformatf("t6 blit_ack%0d", k), 16'(b_back), 16'h0000);
         chk($sformatf("t6 owner%0d", k), 16'(b_owner), (k % 2 == 0) ? 16'(ARB_REGS) : 16'(ARB_NONE));
         if ((k >= 2) && (k % 2 == 0)) begin
            chk($sformatf("t6 data%0d", k), b_data, 16'h2468);
         end
      end
      b_regs_sel = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
